// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-detects NUM_KEYS push buttons.
// Optional auto-repeat of key_press_o is built in when KEY_AUTOREPEAT_EN is defined.
module key_conditioner #(
  parameter int CLK_HZ           = 50000000,
  parameter int DEBOUNCE_MS      = 20,
  parameter int NUM_KEYS         = 3,
  parameter int KEY_ACTIVE_LOW   = 1,
  parameter int REPEAT_DELAY_MS  = 500,
  parameter int REPEAT_PERIOD_MS = 100
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [NUM_KEYS-1:0] key_raw_i,
  output logic [NUM_KEYS-1:0] key_level_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o
);

  localparam int DEB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int CNT_W      = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_DELAY  = CLK_HZ / 1000 * REPEAT_DELAY_MS;
  localparam int REP_PERIOD = CLK_HZ / 1000 * REPEAT_PERIOD_MS;
  localparam int REP_W      = $clog2(REP_DELAY + 1);
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REP_DELAY - REP_PERIOD);
`else
  // Repeat timing parameters are accepted but inert in this build.
  if (REPEAT_DELAY_MS < 0 || REPEAT_PERIOD_MS < 0) begin : g_rep_params_inert
  end
`endif

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  logic [NUM_KEYS-1:0] sync1_d, sync1_q;
  logic [NUM_KEYS-1:0] sync2_d, sync2_q;

  always_comb begin
    if (KEY_ACTIVE_LOW != 0) begin
      sync1_d = ~key_raw_i;
    end else begin
      sync1_d = key_raw_i;
    end
    sync2_d = sync1_q;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_key
      state_e           state_d, state_q;
      logic [CNT_W-1:0] cnt_d, cnt_q;
      logic             level_d, level_q;
      logic             press_d, press_q;
      logic             release_d, release_q;
      logic             sync_s;
      logic             rep_fire_s;

      assign sync_s = sync2_q[g];

`ifdef KEY_AUTOREPEAT_EN
      logic [REP_W-1:0] rep_d, rep_q;

      // Repeat counter advances only while held in PRESSED and freezes across release bounce.
      always_comb begin
        rep_d      = rep_q;
        rep_fire_s = 1'b0;
        case (state_q)
          ST_PRESSED: begin
            if (sync_s) begin
              if (rep_q == REP_LAST) begin
                rep_fire_s = 1'b1;
                rep_d      = REP_RELOAD;
              end else begin
                rep_d = rep_q + 1'b1;
              end
            end else begin
              rep_d = rep_q;
            end
          end
          ST_RELEASE_WAIT: rep_d = rep_q;
          default:         rep_d = '0;
        endcase
      end

      always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
          rep_q <= '0;
        end else begin
          rep_q <= rep_d;
        end
      end
`else
      assign rep_fire_s = 1'b0;
`endif

      always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (sync_s) begin
              state_d = ST_PRESS_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = '0;
            end
          end
          ST_PRESS_WAIT: begin
            if (!sync_s) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
              state_d = ST_PRESSED;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          ST_PRESSED: begin
            if (!sync_s) begin
              state_d = ST_RELEASE_WAIT;
              cnt_d   = '0;
            end else begin
              press_d = rep_fire_s;
            end
          end
          ST_RELEASE_WAIT: begin
            if (sync_s) begin
              state_d = ST_PRESSED;
              cnt_d   = '0;
            end else if (cnt_q >= CNT_LAST) begin
              state_d   = ST_IDLE;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
          end
        endcase
      end

      always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          state_q   <= state_d;
          cnt_q     <= cnt_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
        end
      end

      assign key_level_o[g]   = level_q;
      assign key_press_o[g]   = press_q;
      assign key_release_o[g] = release_q;
    end
  endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed tables plus randomized run vs a run-length model.
module tb_key_conditioner;
  localparam int NK  = 3;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] raw;
  logic [NK-1:0] level_o, press_o, release_o;

  always #5 clk = ~clk;

  key_conditioner #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .NUM_KEYS(NK), .KEY_ACTIVE_LOW(1),
    .REPEAT_DELAY_MS(10), .REPEAT_PERIOD_MS(5)
  ) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .key_raw_i(raw),
    .key_level_o(level_o), .key_press_o(press_o), .key_release_o(release_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a level flips after DEB+1 consecutive synchronised samples that disagree with it.
  logic [NK-1:0] m_q1 = '0, m_q2 = '0, m_level = '0, m_press = '0, m_rel = '0;
  int            m_run  [NK];
  int            m_hold [NK];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic [NK-1:0] r, input logic rs);
    if (rs) begin
      m_q1 = '0; m_q2 = '0; m_level = '0; m_press = '0; m_rel = '0;
      for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_hold[k] = 0; end
    end else begin
      for (int k = 0; k < NK; k++) begin
        logic s;
        int   old_run;
        s = m_q2[k];
        old_run = m_run[k];
        m_press[k] = 1'b0;
        m_rel[k]   = 1'b0;
        if (s != m_level[k]) m_run[k]++; else m_run[k] = 0;
`ifdef KEY_AUTOREPEAT_EN
        if (m_level[k] && s && old_run == 0) begin
          m_hold[k]++;
          if (m_hold[k] >= RD && (m_hold[k] - RD) % RP == 0) m_press[k] = 1'b1;
        end
`endif
        if (m_run[k] == DEB + 1) begin
          m_level[k] = s;
          if (s) m_press[k] = 1'b1; else m_rel[k] = 1'b1;
          m_run[k]  = 0;
          m_hold[k] = 0;
        end
      end
      m_q2 = m_q1;
      m_q1 = ~r;
    end
  endtask

  task automatic tick(input logic [NK-1:0] r, input logic rs);
    @(negedge clk);
    raw = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
    chk("model_outputs", {23'd0, level_o, press_o, release_o}, {23'd0, m_level, m_press, m_rel});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(3'b111, 1'b0);
  endtask

  typedef struct {
    int key;
    int low_n;
    int exp_at;
    int exp_cnt;
  } vec_t;

  vec_t          vecs[5];
  int            at, cnt;
  logic [NK-1:0] rr;
  int            got_rep[$];
  int            exp_rep[$];

  initial begin
    rst = 1'b1;
    raw = 3'b111;
    for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_hold[k] = 0; end

    vecs[0] = '{0, 1, -1, 0};
    vecs[1] = '{1, 3, -1, 0};
    vecs[2] = '{2, 4, -1, 0};
    vecs[3] = '{0, 5, 2 + DEB, 1};
    vecs[4] = '{1, 12, 2 + DEB, 1};

    // Reset state
    for (int i = 0; i < 3; i++) begin
      tick(3'b111, 1'b1);
      chk("reset_outputs", {29'd0, level_o | press_o | release_o}, 32'd0);
    end
    idle(4);

    // Table: low pulse lengths around the debounce window
    for (int i = 0; i < 5; i++) begin
      at = -1; cnt = 0;
      for (int c = 0; c < 14; c++) begin
        rr = 3'b111;
        if (c < vecs[i].low_n) rr[vecs[i].key] = 1'b0;
        tick(rr, 1'b0);
        if (press_o[vecs[i].key]) begin cnt++; if (at < 0) at = c; end
      end
      chk($sformatf("vec%0d_press_at", i), at, vecs[i].exp_at);
      chk($sformatf("vec%0d_press_cnt", i), cnt, vecs[i].exp_cnt);
      idle(12);
    end

    // Bounce on key 1: 5 x (low 3, high 1), then stable low
    cnt = 0; at = -1;
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 3; j++) begin tick(3'b101, 1'b0); cnt += int'(press_o[1]); end
      tick(3'b111, 1'b0); cnt += int'(press_o[1]);
    end
    for (int c = 0; c < 12; c++) begin
      tick(3'b101, 1'b0);
      if (press_o[1]) begin cnt++; if (at < 0) at = c; end
    end
    chk("bounce_pulses", cnt, 1);
    chk("bounce_latency", at, 2 + DEB);
    chk("bounce_level", {31'd0, level_o[1]}, 32'd1);
    idle(14);

    // Release of key 0 with a 2-cycle glitch first
    for (int c = 0; c < 9; c++) tick(3'b110, 1'b0);
    cnt = 0;
    for (int c = 0; c < 2; c++) begin tick(3'b111, 1'b0); cnt += int'(release_o[0]); end
    for (int c = 0; c < 10; c++) begin tick(3'b110, 1'b0); cnt += int'(release_o[0]); end
    chk("glitch_no_release", cnt, 0);
    chk("glitch_level_held", {31'd0, level_o[0]}, 32'd1);
    at = -1; cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick(3'b111, 1'b0);
      if (release_o[0]) begin cnt++; if (at < 0) at = c; end
    end
    chk("release_latency", at, 2 + DEB);
    chk("release_pulses", cnt, 1);
    chk("release_level", {31'd0, level_o[0]}, 32'd0);
    idle(4);

    // Simultaneous press on all keys
    for (int c = 0; c < 9; c++) begin
      tick(3'b000, 1'b0);
      if (c == 2 + DEB) chk("simul_press", {29'd0, press_o}, 32'd7);
    end
    idle(14);

    // Reset mid-window (PRESS_WAIT cnt=2) with key 0 held low
    for (int c = 0; c < 5; c++) tick(3'b110, 1'b0);
    tick(3'b110, 1'b1);
    chk("rst_mid_outputs", {23'd0, level_o, press_o, release_o}, 32'd0);
    at = -1;
    for (int d = 0; d < 10; d++) begin
      tick(3'b110, 1'b0);
      if (press_o[0] && at < 0) at = d;
    end
    chk("rst_mid_press_at", at, 2 + DEB);
    idle(14);

    // Long hold on key 2 (auto-repeat when built in)
`ifdef KEY_AUTOREPEAT_EN
    exp_rep = '{6, 16, 21, 26, 31, 36};
`else
    exp_rep = '{6};
`endif
    for (int c = 0; c < 38; c++) begin
      tick(3'b011, 1'b0);
      if (press_o[2]) got_rep.push_back(c);
    end
    chk("repeat_count", got_rep.size(), exp_rep.size());
    for (int i = 0; i < exp_rep.size() && i < got_rep.size(); i++)
      chk($sformatf("repeat_at%0d", i), got_rep[i], exp_rep[i]);
    idle(14);

    // Randomized traffic against the model, alternating calm and bouncy segments
    rr = 3'b111;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (((c / 200) % 2) == 1) begin
          if ($urandom_range(2) == 0) rr[k] = ~rr[k];
        end else begin
          if ($urandom_range(15) == 0) rr[k] = ~rr[k];
        end
      end
      tick(rr, ($urandom_range(299) == 0) ? 1'b1 : 1'b0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
